fibo_bcd_display: RTL and testbench
===================================

FIBO_BCD_DISPLAY -- requirements
Module: fibo_bcd_display

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 'd50000, giving clock cycles per display digit slot (must be ≥ 2).
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port d_valid, input, 1, input sample strobe, driven by the Fibonacci generator's valid.
REQ-005 The block SHALL have port d_in, input, 16, unsigned binary sample, driven by the generator's output.
REQ-006 The block SHALL have port busy, output, 1, high while a conversion is in progress (state != IDLE).
REQ-007 The block SHALL have port bcd_valid, output, 1, one-cycle pulse when bcd is updated.
REQ-008 The block SHALL have port bcd, output, 20, five BCD digits of the last completed conversion; [3:0] = units.
REQ-009 The block SHALL have port drop_cnt, output, 8, saturating count of rejected samples.
REQ-010 The block SHALL have port an, output, 5, active-low one-hot digit enable.
REQ-011 The block SHALL have port seg, output, 7, active-low segments {g,f,e,d,c,b,a}.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-013 In IDLE with d_valid=1, the block SHALL load d_in into a 16-bit shift register, clear the 20-bit BCD accumulator and the 5-bit shift count, and enter SHIFT.
REQ-014 In SHIFT, each cycle the block SHALL first add 3 to every accumulator digit ≥ 5, then shift {accumulator, shift register} left by 1, then increment the count.
REQ-015 After the 16th shift, the FSM SHALL enter DONE.
REQ-016 In DONE, the block SHALL copy the accumulator to bcd, set bcd_valid=1 for exactly that cycle, and return to IDLE.
REQ-017 Latency SHALL be fixed: sample accepted at edge E0 -> bcd updated and bcd_valid high after edge E17, low again after E18 -> next sample acceptable at E18.
REQ-018 d_valid=1 in SHIFT or DONE SHALL be ignored for data and SHALL increment drop_cnt, which saturates at 8'hFF.
REQ-019 The block SHALL keep bcd stable between bcd_valid pulses.
REQ-020 Inputs up to 16'hFFFF SHALL convert correctly; 65535 -> 20'h65535.
REQ-021 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap the digit index SHALL advance 0->1->2->3->4->0.
REQ-022 an[i]=0 only when index=i; all other bits SHALL be 1.
REQ-023 seg SHALL show the indexed digit of bcd using standard 7-segment patterns: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
REQ-024 Leading-zero blanking: a digit above the most significant non-zero digit SHALL output seg=7'h7F; digit 0 SHALL never be blanked.
REQ-025 The display SHALL run independently of the FSM and SHALL reflect a new bcd from the first slot after the update.

Reset
REQ-026 While reset=1, the block SHALL hold state=IDLE, busy=0, bcd_valid=0, bcd=0, drop_cnt=0, shift count=0, refresh counter=0, digit index=0, an=5'b11110 and seg=7'h40.
REQ-027 Reset asserted mid-conversion SHALL abort it with no bcd_valid pulse and bcd=0; after release, the first d_valid in IDLE SHALL start a fresh conversion.
REQ-028 After reset release, the block SHALL accept a sample from the first rising edge.

Verification
REQ-029 d_in=16'd46368, d_valid pulsed at E0 -> busy high E0..E17, bcd=20'h46368 and bcd_valid=1 after E17 only.
REQ-030 d_in=0 -> bcd=0; scan shows an=5'b11110 with seg=7'h40 and seg=7'h7F in the other four slots.
REQ-031 d_valid held high for 20 edges (E0..E19) -> conversions accepted at E0 and E18, drop_cnt=18.
REQ-032 300 rejected samples -> drop_cnt stays 8'hFF.
REQ-033 Reset pulsed at E8 of a conversion of 16'd1597 -> no bcd_valid, bcd=0; a re-sent 16'd1597 -> bcd=20'h01597, with digit 4 blanked and digits 3..0 showing 1,5,9,7.
REQ-034 REFRESH_DIV=4 with bcd=20'h12345 -> an steps 11110, 11101, 11011, 10111, 01111 every 4 cycles with seg=7'h12, 7'h19, 7'h30, 7'h24, 7'h79.

Source files
------------

// File: rtl/fibo_bcd_display.sv
// Binary-to-BCD converter (shift-and-add-3) feeding a multiplexed
// five-digit seven-segment display with leading-zero blanking.
module fibo_bcd_display #(
  parameter int unsigned REFRESH_DIV = 'd50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        d_valid,
  input  logic [15:0] d_in,
  output logic        busy,
  output logic        bcd_valid,
  output logic [19:0] bcd,
  output logic [7:0]  drop_cnt,
  output logic [4:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] sr;
  logic [19:0] acc;
  logic [19:0] adj;
  logic [4:0]  cnt;
  logic [CW-1:0] refresh;
  logic [2:0]  idx;
  logic [2:0]  msd;
  logic [3:0]  digit;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: 16 shift cycles, then one cycle to publish the result
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (d_valid) state_nxt = SHIFT;
      SHIFT:   if (cnt == 5'd15) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Add 3 to every BCD digit that is 5 or more, ahead of the shift
  always_comb begin
    adj = acc;
    for (int unsigned i = 0; i < 5; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
  end

  // Conversion datapath, result register and drop counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr        <= '0;
      acc       <= '0;
      cnt       <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (d_valid) begin
            sr  <= d_in;
            acc <= '0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          {acc, sr} <= {adj[18:0], sr, 1'b0};
          cnt       <= cnt + 5'd1;
        end
        DONE: begin
          bcd       <= acc;
          bcd_valid <= 1'b1;
        end
        default: ;
      endcase
      if (d_valid && state != IDLE && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Refresh prescaler and digit-slot index
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      refresh <= '0;
      idx     <= '0;
    end else if (refresh == LAST) begin
      refresh <= '0;
      idx     <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
    end else begin
      refresh <= refresh + 1'b1;
    end
  end

  // Position of the most significant non-zero digit (0 when the value is 0)
  always_comb begin
    msd = '0;
    for (int unsigned i = 1; i < 5; i++) begin
      if (bcd[i*4 +: 4] != 4'd0) msd = 3'(i);
    end
  end

  // Digit select for the active slot
  always_comb begin
    digit = '0;
    case (idx)
      3'd0:    digit = bcd[3:0];
      3'd1:    digit = bcd[7:4];
      3'd2:    digit = bcd[11:8];
      3'd3:    digit = bcd[15:12];
      3'd4:    digit = bcd[19:16];
      default: digit = '0;
    endcase
  end

  // Anode enable and segment decode with leading-zero blanking
  always_comb begin
    an  = ~(5'b00001 << idx);
    seg = 7'h7F;
    if (idx <= msd) begin
      case (digit)
        4'd0:    seg = 7'h40;
        4'd1:    seg = 7'h79;
        4'd2:    seg = 7'h24;
        4'd3:    seg = 7'h30;
        4'd4:    seg = 7'h19;
        4'd5:    seg = 7'h12;
        4'd6:    seg = 7'h02;
        4'd7:    seg = 7'h78;
        4'd8:    seg = 7'h00;
        4'd9:    seg = 7'h10;
        default: seg = 7'h7F;
      endcase
    end
  end

endmodule

// File: tb/tb_fibo_bcd_display.sv
// Directed bench for fibo_bcd_display with a fast refresh divider.
module tb_fibo_bcd_display;

  logic        clock;
  logic        reset;
  logic        d_valid;
  logic [15:0] d_in;
  logic        busy;
  logic        bcd_valid;
  logic [19:0] bcd;
  logic [7:0]  drop_cnt;
  logic [4:0]  an;
  logic [6:0]  seg;

  int total = 0;
  int bad   = 0;

  fibo_bcd_display #(.REFRESH_DIV(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .d_valid  (d_valid),
    .d_in     (d_in),
    .busy     (busy),
    .bcd_valid(bcd_valid),
    .bcd      (bcd),
    .drop_cnt (drop_cnt),
    .an       (an),
    .seg      (seg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; d_valid = 1'b0; d_in = '0;
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (bcd_valid !== 1'b0) begin bad++; $display("FAIL reset_bcd_valid got=%b want=0", bcd_valid); end
    total++; if (bcd !== 20'h0) begin bad++; $display("FAIL reset_bcd got=%h want=00000", bcd); end
    total++; if (drop_cnt !== 8'h0) begin bad++; $display("FAIL reset_drop got=%h want=00", drop_cnt); end
    total++; if (an !== 5'b11110) begin bad++; $display("FAIL reset_an got=%b want=11110", an); end
    total++; if (seg !== 7'h40) begin bad++; $display("FAIL reset_seg got=%h want=40", seg); end
    reset = 1'b0;
  endtask

  // One sample, checking busy and bcd_valid timing around edges E0..E18
  task automatic test_convert(input logic [15:0] val, input logic [19:0] exp, input string name);
    d_in = val; d_valid = 1'b1;
    tick();  // E0
    d_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_E0 got=%b want=1", name, busy); end
    for (int e = 1; e <= 16; e++) begin
      tick();
      total++; if (bcd_valid !== 1'b0) begin bad++; $display("FAIL %s early_valid_E%0d got=%b want=0", name, e, bcd_valid); end
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_E16 got=%b want=1", name, busy); end
    tick();  // E17
    total++; if (bcd_valid !== 1'b1) begin bad++; $display("FAIL %s valid_E17 got=%b want=1", name, bcd_valid); end
    total++; if (bcd !== exp) begin bad++; $display("FAIL %s bcd got=%h want=%h", name, bcd, exp); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_E17 got=%b want=0", name, busy); end
    tick();  // E18
    total++; if (bcd_valid !== 1'b0) begin bad++; $display("FAIL %s valid_E18 got=%b want=0", name, bcd_valid); end
    total++; if (bcd !== exp) begin bad++; $display("FAIL %s bcd_hold got=%h want=%h", name, bcd, exp); end
  endtask

  // Leaves simulation on the first cycle of slot 0; returns 0 if never seen
  task automatic sync_slot0(output bit found);
    logic [4:0] prev;
    found = 1'b0;
    prev  = an;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (an == 5'b11110 && prev != 5'b11110) found = 1'b1;
      prev = an;
    end
  endtask

  task automatic test_zero_scan();
    logic [6:0] want;
    bit found;
    test_convert(16'd0, 20'h00000, "zero");
    sync_slot0(found);
    total++; if (!found) begin bad++; $display("FAIL zero_scan_sync got=none want=slot0"); end
    if (found) begin
      for (int s = 0; s < 5; s++) begin
        for (int c = 0; c < 4; c++) begin
          if (s != 0 || c != 0) tick();
          want = (s == 0) ? 7'h40 : 7'h7F;
          total++; if (an !== ~(5'b00001 << s)) begin bad++; $display("FAIL zero_scan_an s=%0d c=%0d got=%b want=%b", s, c, an, ~(5'b00001 << s)); end
          total++; if (seg !== want) begin bad++; $display("FAIL zero_scan_seg s=%0d c=%0d got=%h want=%h", s, c, seg, want); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    total++; if (drop_cnt !== 8'h0) begin bad++; $display("FAIL b2b_drop_clear got=%h want=00", drop_cnt); end
    for (int e = 0; e <= 19; e++) begin
      d_valid = 1'b1;
      d_in = (e == 0) ? 16'd46368 : (e == 18) ? 16'd89 : 16'd999;
      tick();
      if (e == 17) begin
        total++; if (bcd_valid !== 1'b1) begin bad++; $display("FAIL b2b_first_valid got=%b want=1", bcd_valid); end
        total++; if (bcd !== 20'h46368) begin bad++; $display("FAIL b2b_first_bcd got=%h want=46368", bcd); end
      end
    end
    d_valid = 1'b0;
    total++; if (drop_cnt !== 8'd18) begin bad++; $display("FAIL b2b_drop got=%0d want=18", drop_cnt); end
    repeat (15) tick();  // E34
    total++; if (bcd_valid !== 1'b0) begin bad++; $display("FAIL b2b_second_early got=%b want=0", bcd_valid); end
    tick();              // E35
    total++; if (bcd_valid !== 1'b1) begin bad++; $display("FAIL b2b_second_valid got=%b want=1", bcd_valid); end
    total++; if (bcd !== 20'h00089) begin bad++; $display("FAIL b2b_second_bcd got=%h want=00089", bcd); end
    tick();
  endtask

  task automatic test_saturate();
    pulse_reset();
    d_in = 16'd5; d_valid = 1'b1;
    repeat (340) tick();
    d_valid = 1'b0;
    total++; if (drop_cnt !== 8'hFF) begin bad++; $display("FAIL sat_drop got=%h want=ff", drop_cnt); end
    repeat (20) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL sat_idle got=%b want=0", busy); end
    total++; if (drop_cnt !== 8'hFF) begin bad++; $display("FAIL sat_hold got=%h want=ff", drop_cnt); end
  endtask

  task automatic test_reset_abort();
    logic [6:0] want_seg [5];
    int seen;
    bit found;
    want_seg[0] = 7'h78; want_seg[1] = 7'h10; want_seg[2] = 7'h12;
    want_seg[3] = 7'h79; want_seg[4] = 7'h7F;
    d_in = 16'd1597; d_valid = 1'b1;
    tick();  // E0
    d_valid = 1'b0;
    repeat (7) tick();  // E7
    reset = 1'b1;
    tick();  // E8 held in reset
    total++; if (bcd !== 20'h0) begin bad++; $display("FAIL abort_bcd got=%h want=00000", bcd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bcd_valid === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_valid got=%0d pulses want=0", seen); end
    total++; if (bcd !== 20'h0) begin bad++; $display("FAIL abort_bcd_after got=%h want=00000", bcd); end
    test_convert(16'd1597, 20'h01597, "resend");
    sync_slot0(found);
    total++; if (!found) begin bad++; $display("FAIL resend_scan_sync got=none want=slot0"); end
    if (found) begin
      for (int s = 0; s < 5; s++) begin
        for (int c = 0; c < 4; c++) begin
          if (s != 0 || c != 0) tick();
          total++; if (seg !== want_seg[s]) begin bad++; $display("FAIL resend_scan_seg s=%0d c=%0d got=%h want=%h", s, c, seg, want_seg[s]); end
        end
      end
    end
  endtask

  task automatic test_scan_12345();
    logic [4:0] want_an  [5];
    logic [6:0] want_seg [5];
    bit found;
    want_an[0] = 5'b11110; want_an[1] = 5'b11101; want_an[2] = 5'b11011;
    want_an[3] = 5'b10111; want_an[4] = 5'b01111;
    want_seg[0] = 7'h12; want_seg[1] = 7'h19; want_seg[2] = 7'h30;
    want_seg[3] = 7'h24; want_seg[4] = 7'h79;
    test_convert(16'd12345, 20'h12345, "d12345");
    sync_slot0(found);
    total++; if (!found) begin bad++; $display("FAIL scan_sync got=none want=slot0"); end
    if (found) begin
      for (int s = 0; s < 5; s++) begin
        for (int c = 0; c < 4; c++) begin
          if (s != 0 || c != 0) tick();
          total++; if (an !== want_an[s]) begin bad++; $display("FAIL scan_an s=%0d c=%0d got=%b want=%b", s, c, an, want_an[s]); end
          total++; if (seg !== want_seg[s]) begin bad++; $display("FAIL scan_seg s=%0d c=%0d got=%h want=%h", s, c, seg, want_seg[s]); end
        end
      end
      tick();
      total++; if (an !== 5'b11110) begin bad++; $display("FAIL scan_wrap got=%b want=11110", an); end
    end
  endtask

  initial begin
    reset = 1'b1; d_valid = 1'b0; d_in = '0;
    #2;
    test_reset();
    test_convert(16'd46368, 20'h46368, "d46368");
    test_convert(16'hFFFF, 20'h65535, "max");
    test_convert(16'd1, 20'h00001, "one");
    test_zero_scan();
    test_back_to_back();
    test_saturate();
    test_reset_abort();
    test_scan_12345();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
